// File: rtl/uart_nbytes_tx_seq_pkg.sv
// rtl/uart_nbytes_tx_seq_pkg.sv - shared constants and state encoding for the UART byte sequencers
package uart_nbytes_tx_seq_pkg;

  localparam int BYTE_W = 8;

  // State encodings, shared with the receive-side assembler
  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_LOAD = 2'd1;
  localparam logic [1:0] ENC_WAIT = 2'd2;
  localparam logic [1:0] ENC_GAP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_LOAD = ENC_LOAD,
    ST_WAIT = ENC_WAIT,
    ST_GAP  = ENC_GAP
  } seq_state_t;

  // $clog2 that never returns a zero width
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_nbytes_tx_seq_byte_select_mux.sv
// rtl/uart_nbytes_tx_seq_byte_select_mux.sv - combinational NUM_BYTES:1 byte selector with selectable byte order
module byte_select_mux
  import uart_nbytes_tx_seq_pkg::*;
#(
  parameter int NUM_BYTES = 2,
  parameter int MSB_FIRST = 0,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_BYTES*BYTE_W-1:0] bytes_in,
  input  logic [IDX_W-1:0]            sel,
  output logic [BYTE_W-1:0]           byte_out
);

  // Pick byte 'sel' counted from the low end, or from the high end when MSB_FIRST
  always_comb begin
    byte_out = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (sel == IDX_W'(i)) begin
        if (MSB_FIRST != 0) begin
          byte_out = bytes_in[(NUM_BYTES-1-i)*BYTE_W +: BYTE_W];
        end else begin
          byte_out = bytes_in[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

endmodule

// File: rtl/uart_nbytes_tx_seq.sv
// rtl/uart_nbytes_tx_seq.sv - multi-byte transmit sequencer feeding a single-byte UART transmitter
module uart_nbytes_tx_seq
  import uart_nbytes_tx_seq_pkg::*;
#(
  parameter int NUM_BYTES  = 2,
  parameter int MSB_FIRST  = 0,
  parameter int GAP_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_BYTES*8-1:0]         payload,
  input  logic [$clog2(NUM_BYTES+1)-1:0] len,
  input  logic                           done_tx,
  output logic [7:0]                     data,
  output logic                           tx_start,
  output logic                           busy,
  output logic                           done
);

  localparam int LEN_W = $clog2(NUM_BYTES + 1);
  localparam int IDX_W = clog2_min1(NUM_BYTES);
  localparam int GAP_W = clog2_min1(GAP_CYCLES + 1);

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(NUM_BYTES);
  // Counter preload so that GAP lasts exactly GAP_CYCLES clocks
  localparam logic [GAP_W-1:0] GAP_INIT = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  seq_state_t                  state_q, state_d;
  logic [NUM_BYTES*BYTE_W-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]            eff_len_q, eff_len_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [GAP_W-1:0]            gap_cnt_q, gap_cnt_d;
  logic [BYTE_W-1:0]           data_q, data_d;
  logic                        tx_start_q, tx_start_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [BYTE_W-1:0]           sel_byte;
  logic                        last_byte;

  byte_select_mux #(
    .NUM_BYTES (NUM_BYTES),
    .MSB_FIRST (MSB_FIRST),
    .IDX_W     (IDX_W)
  ) u_byte_select_mux (
    .bytes_in (buf_q),
    .sel      (idx_q),
    .byte_out (sel_byte)
  );

  // The byte being waited on is the final one of the frame
  assign last_byte = (LEN_W'(idx_q) == (eff_len_q - LEN_W'(1)));

  // Next-state and registered-output logic; strobes default low so they last one cycle
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    eff_len_d  = eff_len_q;
    idx_d      = idx_q;
    gap_cnt_d  = gap_cnt_q;
    data_d     = data_q;
    busy_d     = busy_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            // Empty frame completes immediately without touching the UART
            done_d = 1'b1;
          end else begin
            buf_d     = payload;
            eff_len_d = (len > MAX_LEN) ? MAX_LEN : len;
            idx_d     = '0;
            busy_d    = 1'b1;
            state_d   = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        data_d     = sel_byte;
        tx_start_d = 1'b1;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (done_tx) begin
          if (last_byte) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (GAP_CYCLES == 0) begin
              state_d = ST_LOAD;
            end else begin
              gap_cnt_d = GAP_INIT;
              state_d   = ST_GAP;
            end
          end
        end
      end

      ST_GAP: begin
        // done_tx is deliberately not looked at here
        if (gap_cnt_q == '0) begin
          state_d = ST_LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without a done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      eff_len_q  <= '0;
      idx_q      <= '0;
      gap_cnt_q  <= '0;
      data_q     <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      eff_len_q  <= eff_len_d;
      idx_q      <= idx_d;
      gap_cnt_q  <= gap_cnt_d;
      data_q     <= data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign data     = data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_nbytes_tx_seq.sv
// tb/tb_uart_nbytes_tx_seq.sv - scoreboard bench for uart_nbytes_tx_seq in three configurations
module tb_uart_nbytes_tx_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // a: 2 bytes LSB first, no gap; b: 4 bytes MSB first; c: 4 bytes LSB first, 3-cycle gap
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [15:0] payload_a = '0;
  logic [31:0] payload_b = '0, payload_c = '0;
  logic [1:0]  len_a = '0;
  logic [2:0]  len_b = '0, len_c = '0;
  logic        resp_a = 1'b0, resp_b = 1'b0, resp_c = 1'b0;
  logic        stray_a = 1'b0;
  wire         done_tx_a = resp_a | stray_a;
  wire         done_tx_b = resp_b;
  wire         done_tx_c = resp_c;
  logic [7:0]  data_a, data_b, data_c;
  logic        tx_start_a, tx_start_b, tx_start_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;

  wire [2:0] done_v = {done_c, done_b, done_a};
  wire [2:0] tx_v   = {tx_start_c, tx_start_b, tx_start_a};

  uart_nbytes_tx_seq #(.NUM_BYTES(2), .MSB_FIRST(0), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .payload(payload_a), .len(len_a),
    .done_tx(done_tx_a), .data(data_a), .tx_start(tx_start_a), .busy(busy_a), .done(done_a));

  uart_nbytes_tx_seq #(.NUM_BYTES(4), .MSB_FIRST(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .payload(payload_b), .len(len_b),
    .done_tx(done_tx_b), .data(data_b), .tx_start(tx_start_b), .busy(busy_b), .done(done_b));

  uart_nbytes_tx_seq #(.NUM_BYTES(4), .MSB_FIRST(0), .GAP_CYCLES(3)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .payload(payload_c), .len(len_c),
    .done_tx(done_tx_c), .data(data_c), .tx_start(tx_start_c), .busy(busy_c), .done(done_c));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int txcnt_a = 0, txcnt_b = 0, txcnt_c = 0;
  int donecnt_a = 0, donecnt_b = 0, donecnt_c = 0;
  int last_dtx_a = -1, last_dtx_c = -1;
  bit arm_a = 1'b0, arm_c = 1'b0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] exp_c[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART models: done_tx 10 clocks after each tx_start; c adds a spurious pulse that lands in GAP
  always begin
    @(posedge clk); #1;
    if (tx_start_a) begin
      repeat (10) @(negedge clk);
      resp_a = 1'b1; @(negedge clk); resp_a = 1'b0;
    end
  end

  always begin
    @(posedge clk); #1;
    if (tx_start_b) begin
      repeat (10) @(negedge clk);
      resp_b = 1'b1; @(negedge clk); resp_b = 1'b0;
    end
  end

  always begin
    @(posedge clk); #1;
    if (tx_start_c) begin
      repeat (10) @(negedge clk);
      resp_c = 1'b1; @(negedge clk); resp_c = 1'b0;
      @(negedge clk);
      resp_c = 1'b1; @(negedge clk); resp_c = 1'b0;
    end
  end

  // Scoreboard: every tx_start pops the expected byte; also checks done_tx-to-tx_start spacing
  always begin
    @(posedge clk); #1;
    cyc++;
    if (tx_start_a) begin
      txcnt_a++;
      check("a_excl", 32'(done_a), 32'd0);
      if (exp_a.size() == 0) check("a_unexp_tx", 32'd1, 32'd0);
      else check("a_byte", 32'(data_a), 32'(exp_a.pop_front()));
      if (last_dtx_a >= 0) check("a_load_lat", 32'(cyc - last_dtx_a), 32'd1);
      arm_a = 1'b1; last_dtx_a = -1;
    end else if (arm_a && done_tx_a) begin
      last_dtx_a = cyc; arm_a = 1'b0;
    end
    if (done_a) begin donecnt_a++; last_dtx_a = -1; arm_a = 1'b0; end

    if (tx_start_b) begin
      txcnt_b++;
      check("b_excl", 32'(done_b), 32'd0);
      if (exp_b.size() == 0) check("b_unexp_tx", 32'd1, 32'd0);
      else check("b_byte", 32'(data_b), 32'(exp_b.pop_front()));
    end
    if (done_b) donecnt_b++;

    if (tx_start_c) begin
      txcnt_c++;
      check("c_excl", 32'(done_c), 32'd0);
      if (exp_c.size() == 0) check("c_unexp_tx", 32'd1, 32'd0);
      else check("c_byte", 32'(data_c), 32'(exp_c.pop_front()));
      if (last_dtx_c >= 0) check("c_gap_lat", 32'(cyc - last_dtx_c), 32'd4);
      arm_c = 1'b1; last_dtx_c = -1;
    end else if (arm_c && done_tx_c) begin
      last_dtx_c = cyc; arm_c = 1'b0;
    end
    if (done_c) begin donecnt_c++; last_dtx_c = -1; arm_c = 1'b0; end

    if (reset) begin
      arm_a = 1'b0; arm_c = 1'b0; last_dtx_a = -1; last_dtx_c = -1;
    end
  end

  // Present start for one edge; returns just after the accepting edge
  task automatic send(input int i, input logic [31:0] p, input logic [2:0] l);
    @(negedge clk);
    case (i)
      0: begin payload_a = p[15:0]; len_a = l[1:0]; start_a = 1'b1; end
      1: begin payload_b = p; len_b = l; start_b = 1'b1; end
      default: begin payload_c = p; len_c = l; start_c = 1'b1; end
    endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic wait_done(input int i, input int max);
    int n;
    for (n = 0; n < max; n++) begin
      @(posedge clk); #1;
      if (done_v[i]) break;
    end
    if (n == max) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_tx(input int i, input int max);
    int n;
    for (n = 0; n < max; n++) begin
      @(posedge clk); #1;
      if (tx_v[i]) break;
    end
    if (n == max) check("tx_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int dn;
    repeat (3) @(posedge clk);
    #1;
    check("a_rst", 32'({data_a, tx_start_a, busy_a, done_a}), 32'd0);
    check("b_rst", 32'({data_b, tx_start_b, busy_b, done_b}), 32'd0);
    check("c_rst", 32'({data_c, tx_start_c, busy_c, done_c}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic two-byte frame, LSB first
    exp_a.push_back(8'hEF); exp_a.push_back(8'hBE);
    send(0, 32'h0000BEEF, 3'd2);
    check("a_busy_on", 32'(busy_a), 32'd1);
    check("a_tx_early", 32'(tx_start_a), 32'd0);
    @(posedge clk); #1;
    check("a_tx_lat", 32'(tx_start_a), 32'd1);
    check("a_first_data", 32'(data_a), 32'hEF);
    wait_done(0, 200);
    check("a_busy_fall", 32'(busy_a), 32'd0);
    check("a_done_align", 32'(done_tx_a), 32'd1);
    @(posedge clk); #1;
    check("a_done_pulse", 32'(done_a), 32'd0);
    repeat (2) @(posedge clk);
    check("a_txcnt1", 32'(txcnt_a), 32'd2);
    check("a_donecnt1", 32'(donecnt_a), 32'd1);

    // Stray done_tx while idle changes nothing
    @(negedge clk); stray_a = 1'b1;
    @(negedge clk); stray_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("a_stray_idle", 32'({data_a, tx_start_a, busy_a, done_a}), 32'({8'hBE, 3'b000}));

    // Restart mid-frame is ignored
    exp_a.push_back(8'h34); exp_a.push_back(8'h12);
    send(0, 32'h00001234, 3'd2);
    repeat (3) @(posedge clk);
    send(0, 32'h00005678, 3'd1);
    wait_done(0, 200);
    check("a_mid_last", 32'(data_a), 32'h12);
    repeat (3) @(posedge clk);
    check("a_txcnt2", 32'(txcnt_a), 32'd4);
    check("a_donecnt2", 32'(donecnt_a), 32'd2);

    // MSB first, partial length
    exp_b.push_back(8'h11); exp_b.push_back(8'h22); exp_b.push_back(8'h33);
    send(1, 32'h11223344, 3'd3);
    wait_done(1, 300);
    check("b_last3", 32'(data_b), 32'h33);
    repeat (3) @(posedge clk);
    check("b_txcnt3", 32'(txcnt_b), 32'd3);

    // Oversized length clamps to four bytes
    exp_b.push_back(8'hA1); exp_b.push_back(8'hB2); exp_b.push_back(8'hC3); exp_b.push_back(8'hD4);
    send(1, 32'hA1B2C3D4, 3'd7);
    wait_done(1, 400);
    repeat (3) @(posedge clk);
    check("b_txcnt7", 32'(txcnt_b), 32'd7);

    // Zero-length frame
    send(1, 32'hFFFFFFFF, 3'd0);
    check("b_len0_done", 32'(done_b), 32'd1);
    check("b_len0_busy", 32'(busy_b), 32'd0);
    check("b_len0_tx", 32'(tx_start_b), 32'd0);
    @(posedge clk); #1;
    check("b_len0_pulse", 32'(done_b), 32'd0);
    repeat (3) @(posedge clk);
    check("b_len0_txcnt", 32'(txcnt_b), 32'd7);
    check("b_donecnt", 32'(donecnt_b), 32'd3);

    // Inter-byte gap with spurious done_tx inside the gap
    exp_c.push_back(8'h11); exp_c.push_back(8'h22); exp_c.push_back(8'h33);
    send(2, 32'h44332211, 3'd3);
    wait_done(2, 400);
    check("c_last", 32'(data_c), 32'h33);
    repeat (6) @(posedge clk);
    check("c_txcnt", 32'(txcnt_c), 32'd3);
    check("c_donecnt", 32'(donecnt_c), 32'd1);

    // Asynchronous reset during the second byte's WAIT
    exp_a.push_back(8'hFE); exp_a.push_back(8'hCA);
    send(0, 32'h0000CAFE, 3'd2);
    wait_tx(0, 50);
    wait_tx(0, 50);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("a_async_rst", 32'({data_a, tx_start_a, busy_a, done_a}), 32'd0);
    dn = donecnt_a;
    repeat (20) @(posedge clk);
    #1;
    check("a_rst_busy", 32'(busy_a), 32'd0);
    check("a_rst_nodone", 32'(donecnt_a), 32'(dn));
    @(negedge clk);
    reset = 1'b0;
    exp_a.push_back(8'h0E); exp_a.push_back(8'h0F);
    send(0, 32'h00000F0E, 3'd2);
    @(posedge clk); #1;
    check("a_post_rst_tx", 32'(tx_start_a), 32'd1);
    check("a_post_rst_b0", 32'(data_a), 32'h0E);
    wait_done(0, 200);
    repeat (15) @(posedge clk);
    check("a_q_empty", 32'(exp_a.size()), 32'd0);
    check("b_q_empty", 32'(exp_b.size()), 32'd0);
    check("c_q_empty", 32'(exp_c.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
